// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_scancode_rx
// Brief   : PS/2 device-to-host receiver; filters PS2_CLK, deframes bytes,
//           strips E0/F0 prefixes and tracks the single held key.
// Revision: 1.0
// ============================================================================
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_H,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] KEYCODE,
    output logic       KEY_VALID,
    output logic       EXTENDED,
    output logic       NEW_CODE,
    output logic [7:0] RAW_BYTE,
    output logic       FRAME_ERR
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t        state_q;
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic [TW-1:0] tcnt_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_ok_q;
    logic          ext_pend_q, brk_pend_q;

    logic          filt_hit_d, fe_d, to_hit_d;

    always_comb begin
        filt_hit_d = (clk_s2_q != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
        fe_d       = filt_hit_d && filt_q;
        to_hit_d   = (state_q != IDLE) && (tcnt_q == TW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_H) begin
            state_q    <= IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            tcnt_q     <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            KEYCODE    <= '0;
            KEY_VALID  <= 1'b0;
            EXTENDED   <= 1'b0;
            NEW_CODE   <= 1'b0;
            RAW_BYTE   <= '0;
            FRAME_ERR  <= 1'b0;
        end else begin
            clk_s1_q  <= PS2_CLK;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= PS2_DAT;
            dat_s2_q  <= dat_s1_q;
            NEW_CODE  <= 1'b0;
            FRAME_ERR <= 1'b0;

            // Any disagreeing run shorter than FILTER_LEN samples is discarded
            if (clk_s2_q == filt_q) begin
                fcnt_q <= '0;
            end else if (filt_hit_d) begin
                filt_q <= clk_s2_q;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end

            if (state_q == IDLE || fe_d) begin
                tcnt_q <= '0;
            end else begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            if (fe_d) begin
                case (state_q)
                    IDLE: begin
                        if (!dat_s2_q) begin
                            state_q  <= DATA;
                            bitcnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q  <= {dat_s2_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok_q <= (^shift_q) ^ dat_s2_q;
                        state_q  <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        if (dat_s2_q && par_ok_q) begin
                            RAW_BYTE <= shift_q;
                            if (shift_q == 8'hE0) begin
                                ext_pend_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brk_pend_q <= 1'b1;
                            end else begin
                                ext_pend_q <= 1'b0;
                                brk_pend_q <= 1'b0;
                                if (brk_pend_q) begin
                                    if (shift_q == KEYCODE && ext_pend_q == EXTENDED) begin
                                        KEYCODE   <= '0;
                                        KEY_VALID <= 1'b0;
                                        EXTENDED  <= 1'b0;
                                        NEW_CODE  <= 1'b1;
                                    end
                                end else begin
                                    KEYCODE   <= shift_q;
                                    EXTENDED  <= ext_pend_q;
                                    KEY_VALID <= 1'b1;
                                    NEW_CODE  <= 1'b1;
                                end
                            end
                        end else begin
                            FRAME_ERR  <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end
                    end
                endcase
            end else if (to_hit_d) begin
                state_q    <= IDLE;
                FRAME_ERR  <= 1'b1;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
